// File: rtl/game_driver_if.sv
// Host-side channel bundle for game_driver.
// Carries the command channel (cmd_valid/cmd_ready plus the command payload)
// and the result channel (res_valid/res_ready plus the result record).
// Modports:
//   master - host/test controller: offers commands and consumes results.
//   slave  - game_driver: accepts commands and presents results.
interface game_driver_if #(
    parameter int N = 4
) ();
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_start_val;
    logic [7:0]   cmd_pattern;
    logic [15:0]  cmd_max;
    logic         res_valid;
    logic         res_ready;
    logic [1:0]   res_who;
    logic [15:0]  res_moves;

    modport master (
        output cmd_valid, cmd_start_val, cmd_pattern, cmd_max, res_ready,
        input  cmd_ready, res_valid, res_who, res_moves
    );

    modport slave (
        input  cmd_valid, cmd_start_val, cmd_pattern, cmd_max, res_ready,
        output cmd_ready, res_valid, res_who, res_moves
    );
endinterface

// File: rtl/game_driver.sv
// game_driver: sequencing front-end for the multimode counter game.
// Accepts one command at a time from the host, loads the game (init /
// initial_val), plays the command's control pattern cyclically, stops on
// gameover or on the move limit, and returns one result record. Keeps
// saturating win / loss / timeout tallies.
// Ports:
//   clk, rst           - clock (rising edge), asynchronous active-low reset
//   host (slave)       - command and result valid/ready channels
//   init, initial_val  - load strobe and load value to the game
//   control            - per-cycle mode code to the game
//   gameover, who      - game status inputs
//   score_clr          - synchronous clear of the tallies
//   wins, losses, timeouts - saturating tallies
// All outputs are registers; nothing depends combinationally on inputs.
module game_driver #(
    parameter int N       = 4,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    game_driver_if.slave       host,
    output logic               init,
    output logic [N-1:0]       initial_val,
    output logic [1:0]         control,
    input  logic               gameover,
    input  logic [1:0]         who,
    input  logic               score_clr,
    output logic [SCORE_W-1:0] wins,
    output logic [SCORE_W-1:0] losses,
    output logic [SCORE_W-1:0] timeouts
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic               cmd_ready_r;
    logic               res_valid_r;
    logic               init_r;
    logic [1:0]         control_r;
    logic [1:0]         control_nxt_s;
    logic [N-1:0]       initial_val_r;
    logic [7:0]         pattern_r;
    logic [15:0]        max_r;
    logic [1:0]         idx_r;
    logic [1:0]         idx_nxt_s;
    logic [15:0]        moves_r;
    logic [1:0]         res_who_r;
    logic [15:0]        res_moves_r;
    logic               run_end_s;
    logic               timeout_s;
    logic [SCORE_W-1:0] wins_r;
    logic [SCORE_W-1:0] losses_r;
    logic [SCORE_W-1:0] timeouts_r;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + SCORE_ONE;
    endfunction

    function automatic logic [15:0] moves_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign host.cmd_ready = cmd_ready_r;
    assign host.res_valid = res_valid_r;
    assign host.res_who   = res_who_r;
    assign host.res_moves = res_moves_r;
    assign init           = init_r;
    assign initial_val    = initial_val_r;
    assign control        = control_r;
    assign wins           = wins_r;
    assign losses         = losses_r;
    assign timeouts       = timeouts_r;

    assign idx_nxt_s = idx_r + 2'd1;

    // Next-state decode; gameover wins over the move limit on the same edge.
    always_comb begin
        state_nxt_s = state_r;
        run_end_s   = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (host.cmd_valid && cmd_ready_r) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (gameover) begin
                    state_nxt_s = ST_REPORT;
                    run_end_s   = 1'b1;
                end else if ((max_r != 16'd0) && (moves_r == max_r)) begin
                    state_nxt_s = ST_REPORT;
                    run_end_s   = 1'b1;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_REPORT: begin
                if (host.res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REPORT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control code for the coming cycle: code 0 on RUN entry, then the code
    // at the advanced index; zero whenever the next cycle is not RUN.
    always_comb begin
        control_nxt_s = 2'd0;
        if (state_nxt_s == ST_RUN) begin
            if (state_r == ST_LOAD) begin
                control_nxt_s = pattern_r[1:0];
            end else begin
                control_nxt_s = pattern_r[{idx_nxt_s, 1'b0} +: 2];
            end
        end else begin
            control_nxt_s = 2'd0;
        end
    end

    // FSM state, registered handshake/strobe outputs and game bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            cmd_ready_r   <= 1'b1;
            res_valid_r   <= 1'b0;
            init_r        <= 1'b0;
            control_r     <= 2'd0;
            initial_val_r <= {N{1'b0}};
            pattern_r     <= 8'd0;
            max_r         <= 16'd0;
            idx_r         <= 2'd0;
            moves_r       <= 16'd0;
            res_who_r     <= 2'd0;
            res_moves_r   <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            res_valid_r <= (state_nxt_s == ST_REPORT);
            init_r      <= (state_nxt_s == ST_LOAD);
            control_r   <= control_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (host.cmd_valid && cmd_ready_r) begin
                        initial_val_r <= host.cmd_start_val;
                        pattern_r     <= host.cmd_pattern;
                        max_r         <= host.cmd_max;
                    end
                end
                ST_LOAD: begin
                    idx_r   <= 2'd0;
                    moves_r <= 16'd1;
                end
                ST_RUN: begin
                    if (run_end_s) begin
                        res_who_r   <= timeout_s ? 2'd3 : who;
                        res_moves_r <= timeout_s ? max_r : moves_r;
                    end else begin
                        idx_r   <= idx_nxt_s;
                        moves_r <= moves_inc(moves_r);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating tallies; clear overrides a same-edge increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wins_r     <= {SCORE_W{1'b0}};
            losses_r   <= {SCORE_W{1'b0}};
            timeouts_r <= {SCORE_W{1'b0}};
        end else if (score_clr) begin
            wins_r     <= {SCORE_W{1'b0}};
            losses_r   <= {SCORE_W{1'b0}};
            timeouts_r <= {SCORE_W{1'b0}};
        end else if (run_end_s) begin
            if (timeout_s) begin
                timeouts_r <= score_inc(timeouts_r);
            end else begin
                case (who)
                    2'd2:    wins_r   <= score_inc(wins_r);
                    2'd1:    losses_r <= score_inc(losses_r);
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
